// File: rtl/adc_frame_fifo.sv
// rtl/adc_frame_fifo.sv - frame-atomic ADC sample FIFO that drops whole frames on overflow
//
// Purpose:
//   Buffers an ADC sample stream (which cannot be back-pressured) in frames
//   delimited by tlast. Words become visible to the DMA side only once their
//   frame has been completely written (committed). A frame that does not fit
//   is discarded in full and overflow pulses once.
//
// Ports:
//   aclk, areset                 clock; synchronous active-high reset
//   s_axis_tvalid/tdata/tlast    ADC sample stream in (no tready)
//   m_axis_tvalid/tready/tdata/tlast  committed frame stream out
//   frames_stored                committed frames not yet fully read (saturating)
//   overflow                     one-cycle pulse per dropped frame
//   frames_dropped               dropped frame count (saturating),
//                                present only with ADC_FIFO_DROP_STATS_EN defined
//
// Build option: define ADC_FIFO_DROP_STATS_EN to add frames_dropped.

module adc_frame_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [15:0]           frames_stored,
    output logic                  overflow
`ifdef ADC_FIFO_DROP_STATS_EN
    ,
    output logic [15:0]           frames_dropped
`endif
);

    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int WORD_W = DATA_WIDTH + 1;
    localparam int DEPTH  = 1 << DEPTH_LOG2;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITING,
        DROPPING
    } wr_state_t;

    // Storage: {tlast, tdata}; contents are never reset.
    logic [WORD_W-1:0] mem [DEPTH];

    // wr_ptr: next write slot of the frame in progress.
    // wr_commit: end of the last complete frame; the read side never passes it.
    // rd_ptr: next word to be transferred out; it only moves on a transfer, so
    //   words sitting in the prefetch stage still occupy their RAM slots.
    // fetch_ptr: next word to be read from RAM into the prefetch stage.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_commit;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fetch_ptr;

    wr_state_t wr_state;

    // Prefetch stage: q is the RAM read register, s the skid register.
    // When both hold data, s is always the older word and drives the output.
    logic              q_valid;
    logic [WORD_W-1:0] q_word;
    logic              s_valid;
    logic [WORD_W-1:0] s_word;

    logic full;
    logic wr_accept;
    logic wr_drop;
    logic commit;
    logic pop;
    logic frame_done;
    logic issue;

    // Full is judged on the pointers before this cycle's updates, so a slot
    // freed by a simultaneous transfer is only usable on the next cycle.
    assign full      = (wr_ptr - rd_ptr) == PTR_FULL;
    assign wr_accept = s_axis_tvalid && (wr_state != DROPPING) && !full;
    assign wr_drop   = s_axis_tvalid && (wr_state != DROPPING) && full;
    assign commit    = wr_accept && s_axis_tlast;

    assign m_axis_tvalid = s_valid || q_valid;
    assign m_axis_tdata  = s_valid ? s_word[DATA_WIDTH-1:0] : q_word[DATA_WIDTH-1:0];
    assign m_axis_tlast  = s_valid ? s_word[DATA_WIDTH] : (q_valid && q_word[DATA_WIDTH]);

    assign pop        = m_axis_tvalid && m_axis_tready;
    assign frame_done = pop && m_axis_tlast;

    // A RAM read may be launched whenever a committed word is left to fetch
    // and the stage will have a free entry at the next edge: the only blocking
    // case is both entries occupied with no transfer this cycle.
    assign issue = (fetch_ptr != wr_commit) && !(s_valid && q_valid && !pop);

    // RAM write port
    always_ff @(posedge aclk) begin
        if (wr_accept && !areset) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Write-side FSM and pointers
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state  <= IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (wr_state)
                IDLE, WRITING: begin
                    if (s_axis_tvalid) begin
                        if (full) begin
                            // Rewind over the partial frame so none of it is
                            // ever exposed, then swallow the rest of the frame.
                            wr_ptr   <= wr_commit;
                            overflow <= 1'b1;
                            wr_state <= s_axis_tlast ? IDLE : DROPPING;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            if (s_axis_tlast) begin
                                wr_commit <= wr_ptr + PTR_ONE;
                                wr_state  <= IDLE;
                            end else begin
                                wr_state  <= WRITING;
                            end
                        end
                    end
                end
                DROPPING: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        wr_state <= IDLE;
                    end
                end
                default: wr_state <= IDLE;
            endcase
        end
    end

    // Read side: RAM read register plus skid register
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_ptr    <= '0;
            fetch_ptr <= '0;
            q_valid   <= 1'b0;
            q_word    <= '0;
            s_valid   <= 1'b0;
            s_word    <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (issue) begin
                fetch_ptr <= fetch_ptr + PTR_ONE;
            end

            if (issue) begin
                q_valid <= 1'b1;
                q_word  <= mem[fetch_ptr[DEPTH_LOG2-1:0]];
            end else if (pop) begin
                // q either was the head and got transferred, or moves into s.
                q_valid <= 1'b0;
            end

            if (s_valid) begin
                if (pop) begin
                    s_valid <= q_valid;
                    s_word  <= q_word;
                end
            end else if (q_valid && !pop && issue) begin
                // Head is stalled but a new read lands in q: park the head in s.
                s_valid <= 1'b1;
                s_word  <= q_word;
            end
        end
    end

    // Committed-frame counter
    always_ff @(posedge aclk) begin
        if (areset) begin
            frames_stored <= '0;
        end else if (commit && !frame_done) begin
            if (frames_stored != 16'hFFFF) begin
                frames_stored <= frames_stored + 16'd1;
            end
        end else if (frame_done && !commit) begin
            if (frames_stored != 16'd0) begin
                frames_stored <= frames_stored - 16'd1;
            end
        end
    end

`ifdef ADC_FIFO_DROP_STATS_EN
    // Dropped-frame counter, advanced on the same edge that raises overflow
    always_ff @(posedge aclk) begin
        if (areset) begin
            frames_dropped <= '0;
        end else if (wr_drop && (frames_dropped != 16'hFFFF)) begin
            frames_dropped <= frames_dropped + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_frame_fifo.sv
// tb/tb_adc_frame_fifo.sv - self-checking bench for adc_frame_fifo

module tb_adc_frame_fifo;

    localparam int DW    = 32;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic [15:0]   frames_stored;
    logic          overflow;
`ifdef ADC_FIFO_DROP_STATS_EN
    logic [15:0]   frames_dropped;
`endif

    adc_frame_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH_LOG2(DL)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .frames_stored (frames_stored),
        .overflow      (overflow)
`ifdef ADC_FIFO_DROP_STATS_EN
        ,
        .frames_dropped(frames_dropped)
`endif
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model: committed words awaiting transfer, words of the frame
    // being written, drop flag and frame counters.
    logic [DW:0] cq[$];
    logic [DW:0] pq[$];
    bit          dropping;
    int          exp_frames;
    int          exp_dropped;
    bit          exp_ovf;

    int          out_count;
    int          frames_out;
    int          dut_ovf;
    int          starve;
    bit          prev_stall;
    logic [DW-1:0] prev_data;
    logic        prev_last;

    logic          smp_v;
    logic [DW-1:0] smp_d;
    logic          smp_l;
    logic [15:0]   smp_fs;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          r;
        logic          ev;
        logic [DW-1:0] ed;
        logic          el;
        logic [15:0]   ef;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, advance the
    // model for the coming rising edge, then check registered outputs.
    task automatic cycle(input bit rst, input bit v, input logic [DW-1:0] d,
                         input bit l, input bit r);
        bit          full;
        logic [DW:0] w;
        areset        = rst;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        m_axis_tready = r;
        @(negedge aclk);
        smp_v  = m_axis_tvalid;
        smp_d  = m_axis_tdata;
        smp_l  = m_axis_tlast;
        smp_fs = frames_stored;
        full = (cq.size() + pq.size()) >= DEPTH;

        if (prev_stall) begin
            chk("stall_valid", 64'(m_axis_tvalid), 64'(1'b1));
            chk("stall_data", 64'(m_axis_tdata), 64'(prev_data));
            chk("stall_last", 64'(m_axis_tlast), 64'(prev_last));
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;

        if (cq.size() != 0 && !m_axis_tvalid) starve++;
        else starve = 0;
        if (starve != 0) begin
            checks++;
            if (starve > 1) begin
                errors++;
                $display("FAIL latency idle_cycles_after_commit %0d required_max 1", starve);
            end
        end

        exp_ovf = 1'b0;
        if (rst) begin
            cq.delete();
            pq.delete();
            dropping    = 1'b0;
            exp_frames  = 0;
            exp_dropped = 0;
            prev_stall  = 1'b0;
            starve      = 0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (cq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual %0h required none", m_axis_tdata);
                end else begin
                    w = cq.pop_front();
                    chk("out_data", 64'(m_axis_tdata), 64'(w[DW-1:0]));
                    chk("out_last", 64'(m_axis_tlast), 64'(w[DW]));
                    out_count++;
                    if (w[DW]) begin
                        exp_frames--;
                        frames_out++;
                    end
                end
            end
            if (v) begin
                if (dropping) begin
                    if (l) dropping = 1'b0;
                end else if (full) begin
                    exp_ovf = 1'b1;
                    exp_dropped++;
                    pq.delete();
                    dropping = !l;
                end else begin
                    pq.push_back({l, d});
                    if (l) begin
                        while (pq.size() != 0) cq.push_back(pq.pop_front());
                        exp_frames++;
                    end
                end
            end
        end

        @(posedge aclk);
        #1;
        if (overflow) dut_ovf++;
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        chk("frames_stored", 64'(frames_stored), 64'(exp_frames));
`ifdef ADC_FIFO_DROP_STATS_EN
        chk("frames_dropped", 64'(frames_dropped), 64'(exp_dropped));
`endif
        if (rst) begin
            chk("rst_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
            chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
            chk("rst_tlast", 64'(m_axis_tlast), 64'(1'b0));
        end
    endtask

    task automatic word(input logic [DW-1:0] d, input bit l, input bit r);
        cycle(1'b0, 1'b1, d, l, r);
    endtask

    task automatic idle(input bit r);
        cycle(1'b0, 1'b0, '0, 1'b0, r);
    endtask

    task automatic reset_dut();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        out_count  = 0;
        frames_out = 0;
        dut_ovf    = 0;
    endtask

    task automatic drain(input bit toggle);
        for (int i = 0; i < 300 && (cq.size() != 0 || m_axis_tvalid); i++) begin
            idle(toggle ? (i % 2 == 0) : 1'b1);
        end
        chk("drain_left", 64'(cq.size()), 64'(0));
        chk("drain_valid", 64'(m_axis_tvalid), 64'(1'b0));
    endtask

    initial begin
        vec_t tbl [18];
        int   ovf_at;
        int   remaining;
        bit   rst;
        bit   rdy;

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;

        // 8-word frame with tready=1: exact cycle-by-cycle expectations
        for (int i = 0; i < 18; i++) begin
            tbl[i].v  = (i < 8);
            tbl[i].d  = (i < 8) ? DW'(i + 1) : '0;
            tbl[i].l  = (i == 7);
            tbl[i].r  = 1'b1;
            tbl[i].ev = (i >= 9 && i <= 16);
            tbl[i].ed = (i >= 9 && i <= 16) ? DW'(i - 8) : '0;
            tbl[i].el = (i == 16);
            tbl[i].ef = (i >= 8 && i <= 16) ? 16'd1 : 16'd0;
        end
        reset_dut();
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk("tbl_valid", 64'(smp_v), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_data", 64'(smp_d), 64'(tbl[i].ed));
                chk("tbl_last", 64'(smp_l), 64'(tbl[i].el));
            end
            chk("tbl_frames", 64'(smp_fs), 64'(tbl[i].ef));
        end
        chk("tbl_ovf_pulses", 64'(dut_ovf), 64'(0));

        // Stalled until commit, then released
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            word(DW'(i + 1), (i == 7), 1'b0);
            chk("precommit_valid", 64'(smp_v), 64'(1'b0));
        end
        idle(1'b0);
        idle(1'b0);
        chk("commit_latency", 64'(smp_v), 64'(1'b1));
        chk("first_word", 64'(smp_d), 64'(1));
        idle(1'b0);
        drain(1'b0);
        chk("stall_frame_words", 64'(out_count), 64'(8));

        // Second frame overflows on its 7th word while the first is held
        reset_dut();
        for (int i = 0; i < 10; i++) word(DW'(100 + i), (i == 9), 1'b0);
        ovf_at = 0;
        for (int i = 0; i < 10; i++) begin
            word(DW'(200 + i), (i == 9), 1'b0);
            if (overflow && ovf_at == 0) ovf_at = i + 1;
        end
        chk("ovf_word_index", 64'(ovf_at), 64'(7));
        chk("ovf_pulses", 64'(dut_ovf), 64'(1));
        chk("held_frames", 64'(frames_stored), 64'(1));
`ifdef ADC_FIFO_DROP_STATS_EN
        chk("dropped_count", 64'(frames_dropped), 64'(1));
`endif
        drain(1'b0);
        chk("a_words_out", 64'(out_count), 64'(10));

        // Oversized frame is dropped, the next one survives
        reset_dut();
        for (int i = 0; i < 20; i++) word(DW'(300 + i), (i == 19), 1'b1);
        chk("long_ovf_pulses", 64'(dut_ovf), 64'(1));
        chk("long_frames", 64'(frames_stored), 64'(0));
        for (int i = 0; i < 3; i++) word(DW'(400 + i), (i == 2), 1'b1);
        drain(1'b0);
        chk("short_words_out", 64'(out_count), 64'(3));

        // Reset in the middle of a frame
        reset_dut();
        for (int i = 0; i < 4; i++) word(DW'(i + 1), 1'b0, 1'b1);
        cycle(1'b1, 1'b1, DW'(5), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) word(DW'(500 + i), (i == 3), 1'b1);
        drain(1'b0);
        chk("post_reset_words", 64'(out_count), 64'(4));
        chk("post_reset_frames", 64'(frames_out), 64'(1));

        // Back-to-back frames with toggling tready
        reset_dut();
        for (int i = 0; i < 15; i++) word(DW'(600 + i), (i % 5 == 4), (i % 2 == 0));
        drain(1'b1);
        chk("b2b_words", 64'(out_count), 64'(15));
        chk("b2b_frames", 64'(frames_out), 64'(3));

        // Randomized traffic against the model
        reset_dut();
        remaining = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 999) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if (remaining == 0 && $urandom_range(0, 3) == 0) begin
                cycle(rst, 1'b0, '0, 1'b0, rdy);
            end else begin
                if (remaining == 0) remaining = $urandom_range(1, 20);
                if ($urandom_range(0, 4) != 0) begin
                    cycle(rst, 1'b1, DW'($urandom), (remaining == 1), rdy);
                    remaining--;
                end else begin
                    cycle(rst, 1'b0, '0, 1'b0, rdy);
                end
            end
        end
        while (remaining > 0) begin
            word(DW'($urandom), (remaining == 1), 1'b1);
            remaining--;
        end
        drain(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_frame_fifo.md
ADC_FRAME_FIFO -- requirements
Module: adc_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the stream word width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, meaning the buffer holds 2^DEPTH_LOG2 words.
REQ-003 SHALL have port aclk, input, 1, the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port areset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports s_axis_tvalid (input, 1), s_axis_tdata (input, DATA_WIDTH) and s_axis_tlast (input, 1), the ADC sample stream; this port has no tready.
REQ-006 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, DATA_WIDTH) and m_axis_tlast (output, 1), the stream towards the DMA writer.
REQ-007 SHALL have port frames_stored, output, 16, the number of committed frames not yet fully read.
REQ-008 SHALL have port overflow, output, 1, a one-cycle pulse on every frame drop.

Function
REQ-009 Storage SHALL be a 2^DEPTH_LOG2 x (DATA_WIDTH+1) RAM holding {tlast, tdata}, with a synchronous read.
REQ-010 wr_ptr, wr_commit and rd_ptr SHALL each be DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1).
REQ-011 "full" SHALL mean (wr_ptr - rd_ptr) == 2^DEPTH_LOG2.
REQ-012 The write FSM SHALL have three states: IDLE, WRITING and DROPPING; the reset state is IDLE.
REQ-013 In IDLE or WRITING, an accepted word (s_axis_tvalid=1 and not full) SHALL be written at wr_ptr, and wr_ptr SHALL increment.
- State goes to WRITING if tlast=0.
- If tlast=1, state goes to IDLE and wr_commit takes the new wr_ptr in the same cycle.
REQ-014 In IDLE or WRITING, s_axis_tvalid=1 while full SHALL discard the word, set wr_ptr to wr_commit, and pulse overflow.
- Next state is IDLE if tlast=1, otherwise DROPPING.
REQ-015 In DROPPING, all words SHALL be discarded; a word with tlast=1 returns the FSM to IDLE.
REQ-016 A frame longer than 2^DEPTH_LOG2 words SHALL always be dropped under REQ-014.
REQ-017 Only committed words (rd_ptr != wr_commit) SHALL be visible on the m_axis side; uncommitted or dropped words never appear.
REQ-018 Latency: a frame committed on cycle N SHALL assert m_axis_tvalid no later than N+2, provided the output stage is empty.
REQ-019 The output SHALL be a two-entry prefetch stage (RAM read register plus skid register).
- m_axis_tdata and m_axis_tlast SHALL stay stable while tvalid=1 and tready=0.
- Sustained throughput SHALL be one word per cycle while tready=1.
REQ-020 A transfer SHALL occur only when m_axis_tvalid=1 and m_axis_tready=1.
REQ-021 frames_stored SHALL increment on every commit and decrement on every transfer with tlast=1.
- If both happen in the same cycle, it SHALL stay unchanged.
- It saturates at 16'hFFFF.
REQ-022 Read and write in the same cycle SHALL both take effect.
- "full" is evaluated on pre-update pointers, so a slot freed in that cycle becomes usable the following cycle.

Reset
REQ-023 With areset=1 at a rising edge, all of the following SHALL reset:
- wr_ptr, wr_commit and rd_ptr to 0;
- FSM to IDLE;
- prefetch stage to empty;
- m_axis_tvalid, m_axis_tlast, overflow and frames_stored to 0;
- m_axis_tdata to 0.
REQ-024 Reset in mid-frame or mid-transfer SHALL discard all buffered data, and the first word after reset SHALL start a new frame.
REQ-025 RAM contents SHALL not be reset.

Configuration
REQ-026 Macro ADC_FIFO_DROP_STATS_EN SHALL add port frames_dropped, output, 16, plus its counter.
- The counter increments on each overflow pulse, saturates at 16'hFFFF, and resets to 0.
- Without the macro, the port and counter are absent; all other behaviour is identical.

Verification
REQ-027 Frame of 8 words (tdata 1..8, tlast on word 8) with tready=1 -> m_axis outputs 1..8, tlast only on 8; frames_stored goes 0->1->0; overflow never asserted.
REQ-028 Same 8-word frame with tready=0 until the frame commits, then tready=1 -> m_axis_tvalid=0 before the commit; output starts within 2 cycles of the commit; data stable during stalls.
REQ-029 DEPTH_LOG2=4 with tready=0: a 10-word frame A, then a 10-word frame B ->
- A is stored; B overflows at its 7th word; one overflow pulse.
- With tready=1 afterwards, only A's 10 words are output.
- With the macro, frames_dropped=1.
REQ-030 DEPTH_LOG2=4, a 20-word frame -> dropped; frames_stored stays 0; a following 3-word frame is output intact.
REQ-031 areset asserted for one cycle at word 5 of an 8-word frame, then a new 4-word frame -> only the 4-word frame is output.
REQ-032 tready toggling 1,0,1,0 during three back-to-back 5-word frames -> all 15 words in order, tlast on words 5, 10 and 15, no duplication or loss.
